// File: rtl/sram_burst_mem.sv
//==============================================================================
// Module   : sram_burst_mem
// Purpose  : Single-port SRAM scratch store with byte-strobed writes,
//            1..2^LEN_WIDTH beat bursts that wrap at DEPTH-1, and separate
//            command / write-data / read-data valid-ready handshakes.
//            After every reset the array is swept to zero before the first
//            command is accepted.
// Ports    : clk_i, clr_i (async, active-high)
//            command  : valid_i, ready_o, wr_rd_en_i, addr_i, len_i
//            write    : wdata_i, wstrb_i, wvalid_i, wready_o
//            read     : rdata_o, rvalid_o, rlast_o, rready_i
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_burst_mem #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [WIDTH/8-1:0]    wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rvalid_o,
    output logic                  rlast_o,
    input  logic                  rready_i
);

    localparam int                    c_NBYTES    = WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;     // shared by init sweep and bursts
    logic [LEN_WIDTH:0]      r_cnt;      // beats committed/issued so far
    logic [LEN_WIDTH-1:0]    r_len;
    logic [WIDTH-1:0]        r_rdata;
    logic                    r_rvalid;
    logic                    r_rlast;
    logic [WIDTH-1:0]        r_mem [DEPTH];

    logic                    w_last_beat;
    logic                    w_beats_left;
    logic                    w_issue;
    logic                    w_wbeat;
    logic                    w_init_we;
    logic                    w_mem_we;
    logic [c_NBYTES-1:0]     w_mem_be;
    logic [WIDTH-1:0]        w_mem_wd;

    // Explicit wrap so non-power-of-two depths never address past the array.
    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == c_LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    // The counter is one bit wider than len so a full-length burst
    // (len = all ones) still has a distinct "all issued" value.
    assign w_last_beat  = (r_cnt == {1'b0, r_len});
    assign w_beats_left = (r_cnt <= {1'b0, r_len});

    // Read output register loads whenever it is empty or being drained.
    assign w_issue   = (r_state == S_READ) && w_beats_left && (!r_rvalid || rready_i);
    assign w_wbeat   = (r_state == S_WRITE) && wvalid_i;
    // Gated by clr_i so the sweep only begins once reset is released.
    assign w_init_we = (r_state == S_INIT) && !clr_i;
    assign w_mem_we  = w_init_we || w_wbeat;
    assign w_mem_be  = w_init_we ? '1 : wstrb_i;
    assign w_mem_wd  = w_init_we ? '0 : wdata_i;

    assign ready_o   = (r_state == S_IDLE);
    assign wready_o  = (r_state == S_WRITE);
    assign rdata_o   = r_rdata;
    assign rvalid_o  = r_rvalid;
    assign rlast_o   = r_rlast;

    // Storage array: no reset, contents are cleared by the INIT sweep.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[r_addr][8*b +: 8] <= w_mem_wd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            r_state  <= S_INIT;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_addr <= f_next_addr(r_addr);
                    if (r_addr == c_LAST_ADDR) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (valid_i) begin
                        r_addr  <= addr_i;
                        r_len   <= len_i;
                        r_cnt   <= '0;
                        r_state <= wr_rd_en_i ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (wvalid_i) begin
                        r_addr <= f_next_addr(r_addr);
                        r_cnt  <= r_cnt + (LEN_WIDTH+1)'(1);
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_rdata  <= r_mem[r_addr];
                        r_rvalid <= 1'b1;
                        r_rlast  <= w_last_beat;
                        r_addr   <= f_next_addr(r_addr);
                        r_cnt    <= r_cnt + (LEN_WIDTH+1)'(1);
                    end else if (r_rvalid && rready_i) begin
                        // Nothing left to issue: this drain ends the burst
                        // when the beat being accepted is the last one.
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_rlast) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/sram_burst_mem.md
# sram_burst_mem

Parametrised single-port SRAM block with byte-strobed writes, multi-beat bursts with address wrap, and separate command, write-data and read-data handshakes. It is the next generation of the team's valid/ready SRAM and sits behind a bus master, or a DMA engine, as local scratch storage. After every reset the block clears its own contents by sweeping all addresses. It accepts no commands until that sweep is complete.

## Interface
- DEPTH, 16, number of words; any value ≥ 2.
- WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- LEN_WIDTH, 2, burst length field width; a burst is 1 to 2^LEN_WIDTH beats.
- clk_i  in  1  single clock; all logic on its rising edge.
- clr_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  command valid.
- ready_o  out  1  command ready; high only in IDLE.
- wr_rd_en_i  in  1  command direction; 1 = write burst, 0 = read burst.
- addr_i  in  ADDR_WIDTH  burst start address.
- len_i  in  LEN_WIDTH  number of beats minus 1.
- wdata_i  in  WIDTH  write beat data.
- wstrb_i  in  WIDTH/8  byte enables; bit k covers wdata_i[8k+7:8k].
- wvalid_i  in  1  write beat valid.
- wready_o  out  1  write beat ready; high only in WRITE.
- rdata_o  out  WIDTH  read beat data, registered.
- rvalid_o  out  1  read beat valid.
- rlast_o  out  1  marks the final read beat.
- rready_i  in  1  read beat accept.

## Operation
- States: INIT, IDLE, WRITE, READ.
- INIT
  - Writes 0 to one location per cycle, at addresses 0 through DEPTH-1.
  - After clearing location DEPTH-1, moves to IDLE.
  - All handshake outputs stay low.
- IDLE
  - ready_o = 1.
  - When valid_i and ready_o are both high at an edge, the block captures addr_i, len_i and wr_rd_en_i.
  - It then moves to WRITE if wr_rd_en_i = 1, or to READ if wr_rd_en_i = 0.
  - wvalid_i and rready_i are ignored in IDLE.
- WRITE
  - wready_o = 1.
  - Each edge with wvalid_i high commits one beat: every byte with its wstrb_i bit set is written into mem[addr]; bytes with a cleared strobe keep their old value.
  - A beat with wstrb_i all zero still counts as a beat.
  - Cycles with wvalid_i low stall the burst; no beat is consumed and no state changes.
  - The edge that commits beat len+1 returns the block to IDLE.
- READ
  - An output register holds rdata_o, rvalid_o and rlast_o.
  - The register loads mem[addr] whenever beats remain to issue and the register is free (rvalid_o = 0, or rready_i = 1).
  - rlast_o = 1 on the final beat only.
  - With rvalid_o = 1 and rready_i = 0, rdata_o and rlast_o hold and rvalid_o stays high.
  - The edge where rvalid_o, rready_i and rlast_o are all high clears rvalid_o and rlast_o and returns the block to IDLE.
- Address arithmetic
  - The address increments by 1 per committed or issued beat.
  - It wraps explicitly from DEPTH-1 to 0, including when DEPTH is not a power of two.
- Beat counter: a LEN_WIDTH+1-bit counter, so a maximum-length burst never aliases.
- Reset
  - clr_i high forces, immediately and without a clock: state INIT, init address 0, ready_o = 0, wready_o = 0, rvalid_o = 0, rlast_o = 0, rdata_o = 0.
  - Any burst in progress is abandoned with no further writes.
  - The INIT sweep starts on the first edge after clr_i falls.

## Timing
- Init duration: ready_o rises DEPTH cycles after the first clock edge that samples clr_i low (16 cycles at default).
- Command handshake: accepted at edge E0; ready_o is low from E0 until the burst completes.
- Write path: wready_o is high from the cycle after E0. With wvalid_i held high, beats commit at edges E1..E(len+1). ready_o is high again in the cycle after the last beat's edge.
- Read path: the first beat appears on rdata_o with rvalid_o high after E1, which is 2 edges after the command is presented.
- Read throughput: with rready_i held high, one beat per cycle and no bubbles.
- Back-to-back bursts: ready_o is high in the cycle after completion, so the minimum gap between bursts is 1 IDLE cycle.
- Write-then-read: a read command accepted right after a write burst returns the newly written data; there is no stale window.

## Test plan
- Init: release clr_i, then count cycles until ready_o rises (required: exactly 16). Read burst at address 0 with len 3 → 4 beats of 0x00000000, with rlast_o high on the 4th beat only.
- Wrap: write burst at address 14, len 3, data 0xA0, 0xA1, 0xA2, 0xA3, wstrb 4'b1111. Read burst at address 14, len 3 → 0xA0, 0xA1, 0xA2, 0xA3. Single-beat reads at addresses 0 and 1 → 0xA2 and 0xA3.
- Strobes: write 0x11223344 to address 5 with wstrb 4'b1111, then write 0xAABBCCDD to address 5 with wstrb 4'b0101. Read address 5 → 0x11BB33DD.
- Backpressure: 4-beat read with rready_i low for 3 cycles after beat 2 → rdata_o, rvalid_o and rlast_o stay stable throughout. Exactly 4 beats in order, none lost or duplicated.
- Write stall: 4-beat write with wvalid_i high only on alternate cycles → all 4 beats written. ready_o stays low until the edge after the 4th beat.
- Reset mid-burst: assert clr_i asynchronously after 2 of 4 write beats → all outputs go to their reset values before the next edge. After 16 init cycles, a 16-beat scan of all locations in single-beat reads returns 0.
